// File: rtl/pll_rst_seq_pkg.sv
// rtl/pll_rst_seq_pkg.sv - shared state encoding and counter sizing for pll_rst_seq
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Width of the shared state counter: enough bits to reach the largest cycle count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser with asynchronous active-high clear
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset pulse, lock qualification and system reset release
// Optional lock-loss counter enabled by defining PLL_RST_SEQ_LOSS_CNT_EN.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2,
  parameter int LOSS_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              sw_rst,
  output logic              pll_rst,
  output logic              rst_out,
  output logic [1:0]        state,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             locked_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .clr(rst),
    .d  (locked),
    .q  (locked_s)
  );

  // sw_rst outranks everything; lock loss outranks count completion.
  always_comb begin
    next_state = cur_state;
    if (sw_rst) begin
      next_state = PLL_RST;
    end else begin
      case (cur_state)
        PLL_RST: begin
          if (cnt == PLL_RST_LAST) next_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s)                 next_state = STABLE;
          else if (cnt == TIMEOUT_LAST) next_state = PLL_RST;
        end
        STABLE: begin
          if (!locked_s)             next_state = WAIT_LOCK;
          else if (cnt == LOCK_LAST) next_state = RUN;
        end
        RUN: begin
          if (!locked_s) next_state = WAIT_LOCK;
        end
        default: next_state = PLL_RST;
      endcase
    end
  end

  // Counter restarts on every state entry and idles in RUN where it is unused.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (sw_rst || (next_state != cur_state) || (cur_state == RUN)) cnt_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_out   <= 1'b1;
    end else begin
      cur_state <= next_state;
      cnt       <= cnt_next;
      pll_rst   <= (next_state == PLL_RST);
      rst_out   <= (next_state != RUN);
    end
  end

  assign state = cur_state;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic              loss_event;
  logic [LOSS_W-1:0] loss_q;

  assign loss_event = !sw_rst && (cur_state == RUN) && !locked_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_event && (loss_q != '1)) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - directed self-checking bench for pll_rst_seq
module tb_pll_rst_seq;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       locked;
  logic       sw_rst;
  logic       pll_rst;
  logic       rst_out;
  logic [1:0] state;
  logic [1:0] loss_cnt;

  int tests_run;
  int tests_failed;

  pll_rst_seq #(
    .PLL_RST_CYCLES(4),
    .LOCK_CYCLES   (8),
    .TIMEOUT_CYCLES(20),
    .SYNC_STAGES   (2),
    .LOSS_W        (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .locked  (locked),
    .sw_rst  (sw_rst),
    .pll_rst (pll_rst),
    .rst_out (rst_out),
    .state   (state),
    .loss_cnt(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after "edge 0", the last edge seen in reset.
  task automatic do_reset(input logic lk);
    rst    = 1'b1;
    sw_rst = 1'b0;
    locked = lk;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_rst = 1'b0; locked = 1'b0;
    step(3);
    tests_run++;
    if ({state, pll_rst, rst_out, loss_cnt} !== {2'd0, 1'b1, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_values: got state=%0d pll_rst=%0b rst_out=%0b loss=%0d, want 0 1 1 0",
               state, pll_rst, rst_out, loss_cnt);
    end
  endtask

  task automatic test_bringup();
    int bad;
    do_reset(1'b0);
    bad = 0;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      if (pll_rst !== 1'b1 || state !== 2'd0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bringup_pll_rst_hold: %0d bad cycles in edges 1-3, want 0", bad);
    end
    step(1); // edge 4
    tests_run++;
    if ({state, pll_rst} !== {2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL bringup_wait_lock: got state=%0d pll_rst=%0b, want 1 0", state, pll_rst);
    end
    step(5); // edge 9
    locked = 1'b1;
    step(2); // edge 11
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL bringup_sync_latency: got state=%0d at edge 11, want 1", state);
    end
    step(1); // edge 12
    tests_run++;
    if (state !== 2'd2) begin
      tests_failed++;
      $display("FAIL bringup_stable_entry: got state=%0d at edge 12, want 2", state);
    end
    step(7); // edge 19
    tests_run++;
    if ({state, rst_out} !== {2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL bringup_pre_run: got state=%0d rst_out=%0b, want 2 1", state, rst_out);
    end
    step(1); // edge 20
    tests_run++;
    if ({state, rst_out, pll_rst} !== {2'd3, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL bringup_run: got state=%0d rst_out=%0b pll_rst=%0b, want 3 0 0",
               state, rst_out, pll_rst);
    end
  endtask

  task automatic test_timeout();
    int bad_pll;
    int bad_rst;
    do_reset(1'b0);
    bad_pll = 0;
    bad_rst = 0;
    for (int e = 1; e <= 60; e++) begin
      step(1);
      if (pll_rst !== ((e % 24) < 4)) bad_pll++;
      if (rst_out !== 1'b1) bad_rst++;
      if (e == 24 && state !== 2'd0) bad_pll++;
      if (e == 47 && state !== 2'd1) bad_pll++;
    end
    tests_run++;
    if (bad_pll !== 0) begin
      tests_failed++;
      $display("FAIL timeout_retry_period: %0d bad cycles, want 0", bad_pll);
    end
    tests_run++;
    if (bad_rst !== 0) begin
      tests_failed++;
      $display("FAIL timeout_rst_out_held: %0d cycles with rst_out low, want 0", bad_rst);
    end
  endtask

  task automatic test_stable_glitch();
    int bad;
    do_reset(1'b1);
    step(5); // edge 5: STABLE entered
    tests_run++;
    if (state !== 2'd2) begin
      tests_failed++;
      $display("FAIL glitch_stable_entry: got state=%0d at edge 5, want 2", state);
    end
    step(4); // edge 9
    locked = 1'b0;
    step(1); // edge 10
    locked = 1'b1;
    step(1); // edge 11
    tests_run++;
    if (state !== 2'd2) begin
      tests_failed++;
      $display("FAIL glitch_before_drop: got state=%0d at edge 11, want 2", state);
    end
    step(1); // edge 12
    tests_run++;
    if ({state, rst_out} !== {2'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL glitch_back_to_wait: got state=%0d rst_out=%0b, want 1 1", state, rst_out);
    end
    bad = 0;
    for (int e = 13; e <= 20; e++) begin
      step(1);
      if (rst_out !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0 || state !== 2'd2) begin
      tests_failed++;
      $display("FAIL glitch_requalify: %0d early releases, state=%0d at edge 20, want 0 and 2",
               bad, state);
    end
    step(1); // edge 21
    tests_run++;
    if ({state, rst_out} !== {2'd3, 1'b0}) begin
      tests_failed++;
      $display("FAIL glitch_run: got state=%0d rst_out=%0b, want 3 0", state, rst_out);
    end
  endtask

  task automatic test_lock_loss();
    logic [1:0] exp_loss;
    for (int i = 1; i <= 4; i++) begin
      locked = 1'b0;
      step(2);
      tests_run++;
      if ({state, rst_out} !== {2'd3, 1'b0}) begin
        tests_failed++;
        $display("FAIL loss%0d_still_run: got state=%0d rst_out=%0b, want 3 0", i, state, rst_out);
      end
      step(1);
      exp_loss = LOSS_EN ? ((i > 3) ? 2'd3 : 2'(i)) : 2'd0;
      tests_run++;
      if ({state, rst_out, pll_rst, loss_cnt} !== {2'd1, 1'b1, 1'b0, exp_loss}) begin
        tests_failed++;
        $display("FAIL loss%0d_exit_run: got state=%0d rst_out=%0b pll_rst=%0b loss=%0d, want 1 1 0 %0d",
                 i, state, rst_out, pll_rst, loss_cnt, exp_loss);
      end
      locked = 1'b1;
      step(11);
      tests_run++;
      if (state !== 2'd3) begin
        tests_failed++;
        $display("FAIL loss%0d_rerun: got state=%0d, want 3", i, state);
      end
    end
  endtask

  task automatic test_sw_rst_priority();
    logic [1:0] exp_loss;
    int bad;
    exp_loss = LOSS_EN ? 2'd3 : 2'd0;
    locked = 1'b0;
    step(2);
    sw_rst = 1'b1;
    step(1);
    tests_run++;
    if ({state, pll_rst, rst_out, loss_cnt} !== {2'd0, 1'b1, 1'b1, exp_loss}) begin
      tests_failed++;
      $display("FAIL swrst_priority: got state=%0d pll_rst=%0b rst_out=%0b loss=%0d, want 0 1 1 %0d",
               state, pll_rst, rst_out, loss_cnt, exp_loss);
    end
    step(6);
    sw_rst = 1'b0;
    bad = 0;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      if (state !== 2'd0 || pll_rst !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL swrst_full_pulse: %0d short cycles after release, want 0", bad);
    end
    step(1);
    tests_run++;
    if ({state, pll_rst} !== {2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL swrst_to_wait: got state=%0d pll_rst=%0b, want 1 0", state, pll_rst);
    end
  endtask

  task automatic test_async_reset();
    locked = 1'b1;
    step(3);
    tests_run++;
    if (state !== 2'd2) begin
      tests_failed++;
      $display("FAIL async_setup: got state=%0d, want 2", state);
    end
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({state, pll_rst, rst_out, loss_cnt} !== {2'd0, 1'b1, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got state=%0d pll_rst=%0b rst_out=%0b loss=%0d, want 0 1 1 0",
               state, pll_rst, rst_out, loss_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    locked = 1'b0;
    sw_rst = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_stable_glitch();
    test_lock_loss();
    test_sw_rst_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
